// File: rtl/qam_tx_pkg.sv
// -----------------------------------------------------------------------------
// qam_tx_pkg
//
// Shared definitions for the QAM transmit front end. This package holds the
// default symbol and rate widths, the all-zero symbol that is used for stuffed
// and underrun samples, and the phase-state encoding used by the upsampler.
//
// No ports. Contents:
//   SYM_W         default symbol width (QAM-16 packs 4 bits per symbol)
//   RATE_W        default width of the upsampling rate input
//   ZERO_SYM      symbol value driven on zero-inserted / underrun samples
//   phase_state_e IDLE (sample side parked) / RUN (emitting one sample per clk)
// -----------------------------------------------------------------------------
package qam_tx_pkg;

    localparam int SYM_W  = 4;
    localparam int RATE_W = 9;

    localparam logic [SYM_W-1:0] ZERO_SYM = 4'h0;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } phase_state_e;

endpackage

// File: rtl/qam_sym_fifo.sv
// -----------------------------------------------------------------------------
// qam_sym_fifo
//
// Small synchronous FIFO that holds packed QAM symbols between the bit
// assembler and the sample-output side of the upsampler. Pointers carry one
// extra wrap bit so that full and empty are told apart without a counter.
// Full and empty are kept as registered flags so they can drive handshake
// outputs directly without a combinational path from push/pop.
//
// Ports:
//   clk        in   single clock
//   rst        in   asynchronous active-high reset (pointers and flags)
//   push_i     in   write wr_data_i; ignored while full
//   wr_data_i  in   symbol to store
//   pop_i      in   discard the head entry; ignored while empty
//   rd_data_o  out  current head entry (valid while not empty)
//   full_o     out  registered full flag
//   empty_o    out  registered empty flag
// -----------------------------------------------------------------------------
module qam_sym_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [AW:0] wr_ptr_q;
    logic [AW:0] wr_ptr_d;
    logic [AW:0] rd_ptr_q;
    logic [AW:0] rd_ptr_d;
    logic        full_q;
    logic        full_d;
    logic        empty_q;
    logic        empty_d;
    logic        do_push;
    logic        do_pop;

    assign do_push = push_i && !full_q;
    assign do_pop  = pop_i && !empty_q;

    // Advance each pointer on its own qualified request. The flags are derived
    // from the next pointer values so they are ready as registers on the same
    // edge that changes occupancy; a simultaneous push and pop leaves both
    // flags where they were.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        empty_d = (wr_ptr_d == rd_ptr_d);
        full_d  = (wr_ptr_d[AW] != rd_ptr_d[AW]) &&
                  (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
    end

    // Pointer and flag registers. Reset empties the FIFO; stored data is left
    // alone because it is unreachable once the pointers are equal.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    // Storage array. Only the low pointer bits address it; the wrap bit exists
    // purely for the full/empty distinction.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_ptr_q[AW-1:0]];
    assign full_o    = full_q;
    assign empty_o   = empty_q;

endmodule

// File: rtl/qam_symbol_upsampler.sv
// -----------------------------------------------------------------------------
// qam_symbol_upsampler
//
// Feeds the upsampling interpolation filter. A serial payload bitstream is
// accepted over a valid/ready handshake, packed MSB-first into 4-bit QAM
// symbols and queued in qam_sym_fifo. The output side then emits one sample
// per clock: a real symbol on phase 0 of each symbol period, followed by
// L_eff-1 stuffed samples, where L_eff = max(upsampling_rate, 1).
//
// Build option:
//   QAM_SYMBOL_HOLD_EN  defined   -> stuffed samples repeat the last phase-0
//                                    value (sample-and-hold)
//                       undefined -> stuffed samples are zero (zero insertion)
//
// Ports:
//   clk              in   single clock
//   rst              in   asynchronous active-high reset
//   enable           in   runs the sample-output side
//   bit_in           in   payload bit
//   bit_valid        in   bit_in is valid
//   bit_ready        out  block can accept a bit (registered FIFO-not-full)
//   upsampling_rate  in   samples per symbol; 0 and 1 both mean no stuffing
//   data_out         out  sample to the filter (registered)
//   sample_valid     out  data_out is valid this cycle (registered)
//   sym_strobe       out  data_out is a real symbol (registered)
//   underrun         out  one-cycle pulse: a symbol slot found the FIFO empty
//   underrun_sticky  out  latched underrun, cleared only by rst
// -----------------------------------------------------------------------------
module qam_symbol_upsampler #(
    parameter int SYM_W      = qam_tx_pkg::SYM_W,
    parameter int FIFO_DEPTH = 4,
    parameter int RATE_W     = qam_tx_pkg::RATE_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              bit_in,
    input  logic              bit_valid,
    output logic              bit_ready,
    input  logic [RATE_W-1:0] upsampling_rate,
    output logic [SYM_W-1:0]  data_out,
    output logic              sample_valid,
    output logic              sym_strobe,
    output logic              underrun,
    output logic              underrun_sticky
);

    import qam_tx_pkg::*;

    localparam int                CNT_W    = $clog2(SYM_W);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(SYM_W - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [RATE_W-1:0] RATE_ONE = RATE_W'(1);

    logic [SYM_W-2:0]  shift_q;
    logic [SYM_W-2:0]  shift_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic              bit_accept;
    logic              fifo_push;
    logic [SYM_W-1:0]  fifo_wr_data;
    logic              fifo_pop;
    logic [SYM_W-1:0]  fifo_rd_data;
    logic              fifo_full;
    logic              fifo_empty;

    phase_state_e      state_q;
    phase_state_e      state_d;
    logic [RATE_W-1:0] phase_q;
    logic [RATE_W-1:0] phase_d;
    logic [RATE_W-1:0] rate_q;
    logic [RATE_W-1:0] rate_d;
    logic [RATE_W-1:0] rate_eff;
    logic [SYM_W-1:0]  data_q;
    logic [SYM_W-1:0]  data_d;
    logic              valid_q;
    logic              valid_d;
    logic              strobe_q;
    logic              strobe_d;
    logic              underrun_q;
    logic              underrun_d;
    logic              sticky_q;
    logic              sticky_d;
`ifdef QAM_SYMBOL_HOLD_EN
    logic [SYM_W-1:0]  hold_q;
    logic [SYM_W-1:0]  hold_d;
`endif

    // Ready comes straight from the registered full flag, so a pop on the
    // same edge does not open the door for a bit until the following cycle.
    assign bit_ready  = !fifo_full;
    assign bit_accept = bit_valid && !fifo_full;

    // The completed symbol is the three bits already shifted in followed by
    // the bit arriving now, so the first bit of each group lands in the MSB.
    assign fifo_wr_data = {shift_q, bit_in};

    // Bit assembler: count accepted bits 0..SYM_W-1 and push on the last one.
    // The shift register does not need clearing on wrap because the next
    // group completely overwrites it before it is pushed again. Nothing here
    // depends on enable, so a partial symbol survives enable toggling.
    always_comb begin
        shift_d   = shift_q;
        cnt_d     = cnt_q;
        fifo_push = 1'b0;
        if (bit_accept) begin
            if (cnt_q == CNT_LAST) begin
                fifo_push = 1'b1;
                cnt_d     = '0;
            end else begin
                shift_d = {shift_q[SYM_W-3:0], bit_in};
                cnt_d   = cnt_q + CNT_ONE;
            end
        end
    end

    // Assembler registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
        end
    end

    qam_sym_fifo #(
        .WIDTH (SYM_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push_i    (fifo_push),
        .wr_data_i (fifo_wr_data),
        .pop_i     (fifo_pop),
        .rd_data_o (fifo_rd_data),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty)
    );

    // A rate of zero is treated as one so the phase counter always has at
    // least one phase and never wraps through an empty period.
    assign rate_eff = (upsampling_rate == '0) ? RATE_ONE : upsampling_rate;

    // Phase FSM and next output values. Entering RUN spends one edge arming
    // the counter at phase 0; each later edge in RUN produces one sample.
    // Dropping enable aborts the symbol period on the next edge and the
    // outputs return to zero. The rate is captured only at phase 0 so a
    // mid-period change cannot stretch or shorten the symbol being emitted.
    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        rate_d     = rate_q;
        fifo_pop   = 1'b0;
        data_d     = ZERO_SYM;
        valid_d    = 1'b0;
        strobe_d   = 1'b0;
        underrun_d = 1'b0;
        sticky_d   = sticky_q;
`ifdef QAM_SYMBOL_HOLD_EN
        hold_d     = hold_q;
`endif
        case (state_q)
            IDLE: begin
                phase_d = '0;
                if (enable) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (!enable) begin
                    state_d = IDLE;
                    phase_d = '0;
                end else begin
                    valid_d = 1'b1;
                    if (phase_q == '0) begin
                        rate_d  = rate_eff;
                        phase_d = (rate_eff == RATE_ONE) ? '0 : RATE_ONE;
                        if (!fifo_empty) begin
                            fifo_pop = 1'b1;
                            data_d   = fifo_rd_data;
                            strobe_d = 1'b1;
`ifdef QAM_SYMBOL_HOLD_EN
                            hold_d   = fifo_rd_data;
`endif
                        end else begin
                            underrun_d = 1'b1;
                            sticky_d   = 1'b1;
`ifdef QAM_SYMBOL_HOLD_EN
                            hold_d     = ZERO_SYM;
`endif
                        end
                    end else begin
`ifdef QAM_SYMBOL_HOLD_EN
                        data_d = hold_q;
`else
                        data_d = ZERO_SYM;
`endif
                        phase_d = (phase_q == rate_q - RATE_ONE) ? '0 : phase_q + RATE_ONE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                phase_d = '0;
            end
        endcase
    end

    // Phase state and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            phase_q    <= '0;
            rate_q     <= RATE_ONE;
            data_q     <= ZERO_SYM;
            valid_q    <= 1'b0;
            strobe_q   <= 1'b0;
            underrun_q <= 1'b0;
            sticky_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            rate_q     <= rate_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            strobe_q   <= strobe_d;
            underrun_q <= underrun_d;
            sticky_q   <= sticky_d;
        end
    end

`ifdef QAM_SYMBOL_HOLD_EN
    // Last phase-0 value, repeated on the stuffed phases.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_q <= ZERO_SYM;
        end else begin
            hold_q <= hold_d;
        end
    end
`endif

    assign data_out        = data_q;
    assign sample_valid    = valid_q;
    assign sym_strobe      = strobe_q;
    assign underrun        = underrun_q;
    assign underrun_sticky = sticky_q;

endmodule

// File: tb/tb_qam_symbol_upsampler.sv
// -----------------------------------------------------------------------------
// tb_qam_symbol_upsampler
//
// Directed bench for qam_symbol_upsampler. Stimulus tasks push the expected
// output samples into a queue; an independent monitor pops and compares them
// on every falling edge where the DUT reports sample_valid. Expectations for
// the stuffed phases follow QAM_SYMBOL_HOLD_EN when the bench is compiled.
// -----------------------------------------------------------------------------
module tb_qam_symbol_upsampler;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic       bit_in;
    logic       bit_valid;
    logic       bit_ready;
    logic [8:0] upsampling_rate;
    logic [3:0] data_out;
    logic       sample_valid;
    logic       sym_strobe;
    logic       underrun;
    logic       underrun_sticky;

    typedef struct packed {
        logic [3:0] data;
        logic       strobe;
        logic       under;
    } sample_t;

    sample_t expQ[$];
    int      vectors     = 0;
    int      miscompares = 0;
    bit      strobeOnly  = 1'b0;

    qam_symbol_upsampler dut (
        .clk             (clk),
        .rst             (rst),
        .enable          (enable),
        .bit_in          (bit_in),
        .bit_valid       (bit_valid),
        .bit_ready       (bit_ready),
        .upsampling_rate (upsampling_rate),
        .data_out        (data_out),
        .sample_valid    (sample_valid),
        .sym_strobe      (sym_strobe),
        .underrun        (underrun),
        .underrun_sticky (underrun_sticky)
    );

    always #5 clk = ~clk;

    // One comparison: counts, and reports a FAIL line on mismatch.
    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
        vectors++;
        if (actual !== required) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, required);
        end
    endtask

    // Expected value of a stuffed phase given the last phase-0 value.
    function automatic logic [3:0] stuffVal(input logic [3:0] last);
`ifdef QAM_SYMBOL_HOLD_EN
        return last;
`else
        return 4'h0 & last;
`endif
    endfunction

    task automatic pushSample(input logic [3:0] d, input logic s, input logic u);
        sample_t e;
        e.data   = d;
        e.strobe = s;
        e.under  = u;
        expQ.push_back(e);
    endtask

    task automatic expectSymbol(input logic [3:0] sym, input int rate);
        pushSample(sym, 1'b1, 1'b0);
        for (int k = 1; k < rate; k++) pushSample(stuffVal(sym), 1'b0, 1'b0);
    endtask

    task automatic expectUnderrun(input int rate);
        pushSample(4'h0, 1'b0, 1'b1);
        for (int k = 1; k < rate; k++) pushSample(stuffVal(4'h0), 1'b0, 1'b0);
    endtask

    // Drive one bit with valid held until the DUT shows ready; the rising edge
    // between this falling edge and the next one takes the bit.
    task automatic sendBit(input logic b);
        int waitCnt;
        waitCnt   = 0;
        bit_in    = b;
        bit_valid = 1'b1;
        while (!bit_ready && waitCnt < 200) begin
            @(negedge clk);
            waitCnt++;
        end
        if (!bit_ready) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL bit_ready timeout: got 0, expected 1");
        end
        @(negedge clk);
        bit_valid = 1'b0;
    endtask

    // Send one symbol MSB-first.
    task automatic applyStimulus(input logic [3:0] sym);
        for (int i = 3; i >= 0; i--) sendBit(sym[i]);
    endtask

    task automatic checkReset();
        checkOutput("reset data_out", 32'(data_out), 32'h0);
        checkOutput("reset sample_valid", 32'(sample_valid), 32'h0);
        checkOutput("reset sym_strobe", 32'(sym_strobe), 32'h0);
        checkOutput("reset underrun", 32'(underrun), 32'h0);
        checkOutput("reset underrun_sticky", 32'(underrun_sticky), 32'h0);
        checkOutput("reset bit_ready", 32'(bit_ready), 32'h1);
    endtask

    task automatic doReset();
        enable    = 1'b0;
        bit_valid = 1'b0;
        bit_in    = 1'b0;
        rst       = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    // Wait (bounded) for the monitor to consume every expected sample.
    task automatic drainCheck(input string name);
        int w;
        w = 0;
        while (expQ.size() != 0 && w < 50) begin
            @(negedge clk);
            w++;
        end
        checkOutput(name, 32'(expQ.size()), 32'h0);
        expQ.delete();
    endtask

    // Enable for exactly n output samples: one arming edge, then n samples.
    task automatic runSamples(input int n, input string name);
        enable = 1'b1;
        repeat (n + 1) @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        drainCheck(name);
    endtask

    // Scoreboard monitor.
    initial begin : monitor
        sample_t e;
        forever begin
            @(negedge clk);
            if (!rst && sample_valid) begin
                if (strobeOnly) begin
                    if (sym_strobe) begin
                        if (expQ.size() == 0) begin
                            vectors++;
                            miscompares++;
                            $display("[TB] FAIL extra symbol: got %0h, expected none", data_out);
                        end else begin
                            e = expQ.pop_front();
                            checkOutput("stream symbol", 32'(data_out), 32'(e.data));
                        end
                    end
                end else if (expQ.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("[TB] FAIL extra sample: got data %0h strobe %0b, expected none", data_out, sym_strobe);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("sample data_out", 32'(data_out), 32'(e.data));
                    checkOutput("sample sym_strobe", 32'(sym_strobe), 32'(e.strobe));
                    checkOutput("sample underrun", 32'(underrun), 32'(e.under));
                end
            end
        end
    end

    // Watchdog.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst             = 1'b1;
        enable          = 1'b0;
        bit_valid       = 1'b0;
        bit_in          = 1'b0;
        upsampling_rate = 9'd4;
        repeat (2) @(negedge clk);

        // Reset values.
        checkReset();
        rst = 1'b0;
        @(negedge clk);

        // No input, L=4: underrun on every phase 0.
        $display("[TB] underrun with empty FIFO, L=4");
        upsampling_rate = 9'd4;
        expectUnderrun(4);
        expectUnderrun(4);
        runSamples(8, "underrun drain");
        checkOutput("sticky after underrun", 32'(underrun_sticky), 32'h1);

        // Bits 1011 0010 -> B then 2.
        $display("[TB] two symbols, L=4");
        doReset();
        upsampling_rate = 9'd4;
        applyStimulus(4'hB);
        applyStimulus(4'h2);
        expectSymbol(4'hB, 4);
        expectSymbol(4'h2, 4);
        runSamples(8, "two symbol drain");
        checkOutput("sticky without underrun", 32'(underrun_sticky), 32'h0);

        // L=1: fill the FIFO, see back-pressure, then stream more symbols.
        $display("[TB] L=1 fill and stream");
        doReset();
        upsampling_rate = 9'd1;
        strobeOnly      = 1'b1;
        pushSample(4'hA, 1'b1, 1'b0);
        pushSample(4'h5, 1'b1, 1'b0);
        pushSample(4'hC, 1'b1, 1'b0);
        pushSample(4'h3, 1'b1, 1'b0);
        pushSample(4'h9, 1'b1, 1'b0);
        pushSample(4'h6, 1'b1, 1'b0);
        pushSample(4'hF, 1'b1, 1'b0);
        applyStimulus(4'hA);
        applyStimulus(4'h5);
        applyStimulus(4'hC);
        applyStimulus(4'h3);
        checkOutput("bit_ready when full", 32'(bit_ready), 32'h0);
        fork
            begin
                applyStimulus(4'h9);
                applyStimulus(4'h6);
                applyStimulus(4'hF);
            end
            begin
                @(negedge clk);
                enable = 1'b1;
            end
        join
        repeat (10) @(negedge clk);
        enable = 1'b0;
        repeat (2) @(negedge clk);
        drainCheck("stream drain");
        strobeOnly = 1'b0;

        // Rate 3 -> 5 changed during phase 1 of the first period.
        $display("[TB] rate change mid-symbol");
        doReset();
        upsampling_rate = 9'd3;
        applyStimulus(4'h6);
        applyStimulus(4'h9);
        expectSymbol(4'h6, 3);
        expectSymbol(4'h9, 5);
        enable = 1'b1;
        @(negedge clk);
        @(negedge clk);
        upsampling_rate = 9'd5;
        repeat (7) @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        drainCheck("rate change drain");

        // Rate 0 behaves as L=1.
        $display("[TB] rate zero");
        doReset();
        upsampling_rate = 9'd0;
        applyStimulus(4'hC);
        applyStimulus(4'hD);
        expectSymbol(4'hC, 1);
        expectSymbol(4'hD, 1);
        expectUnderrun(1);
        runSamples(3, "rate zero drain");

        // Reset with queued symbols and a partial symbol pending.
        $display("[TB] reset mid-operation");
        applyStimulus(4'h1);
        applyStimulus(4'h2);
        applyStimulus(4'h4);
        sendBit(1'b1);
        sendBit(1'b1);
        checkOutput("sticky before reset", 32'(underrun_sticky), 32'h1);
        expectSymbol(4'h1, 1);
        enable = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1;
        rst    = 1'b1;
        enable = 1'b0;
        #1;
        checkReset();
        @(negedge clk);
        rst = 1'b0;
        drainCheck("pre-reset drain");
        @(negedge clk);
        applyStimulus(4'h5);
        expectSymbol(4'h5, 1);
        expectUnderrun(1);
        runSamples(2, "post-reset drain");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
